// File: rtl/fifo_pkg.sv
// Shared types and constants for the single-clock framed FIFO.
package fifo_pkg;

  typedef enum logic {
    GATED   = 1'b0,
    RELEASE = 1'b1
  } gate_state_t;

  localparam int CNT_W = 16;

  function automatic int depth(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/m_ram_2port_sync.sv
// Simple dual-port RAM with one write port and a registered read port.
// The read register doubles as the FIFO output word, so it is clearable.
module m_ram_2port_sync #(
  parameter int WIDTH = 36,
  parameter int AW    = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_clr)   r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/m_fifo_sync_pkt.sv
// Single-clock framed FIFO: RAM plus output register, with an optional
// gate that releases data only once a complete frame is stored.
module m_fifo_sync_pkt
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 9,
  parameter int PKT_MODE   = 1,
  parameter int EOF_BIT    = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] datain,
  input  logic             src_rdy_i,
  output logic             dst_rdy_o,
  output logic [WIDTH-1:0] dataout,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i,
  output logic [15:0]      space,
  output logic [15:0]      occupied,
  output logic [15:0]      pkt_count
);

  localparam logic [CNT_W-1:0]      DEPTH   = CNT_W'(depth(DEPTH_LOG2));
  localparam logic [CNT_W-1:0]      ONE     = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_ram_cnt;
  logic [CNT_W-1:0]      r_occ;
  logic [CNT_W-1:0]      r_pkt_cnt;
  logic                  r_out_vld;
  gate_state_t           r_state;

  logic w_wr;
  logic w_rd;
  logic w_load;
  logic w_gate_open;
  logic w_inc;
  logic w_dec;

  assign dst_rdy_o   = (r_occ != DEPTH);
  assign w_wr        = src_rdy_i & dst_rdy_o;
  assign w_gate_open = (PKT_MODE == 0) || (r_state == RELEASE) || (r_pkt_cnt != '0);
  assign src_rdy_o   = r_out_vld & w_gate_open;
  assign w_rd        = src_rdy_o & dst_rdy_i;
  // Refill the output word from RAM whenever it is empty or being consumed;
  // r_ram_cnt excludes a word written at this edge, so no read-during-write.
  assign w_load      = (r_ram_cnt != '0) & (~r_out_vld | w_rd);
  assign w_inc       = w_wr & datain[EOF_BIT];
  assign w_dec       = w_rd & dataout[EOF_BIT];

  assign occupied  = r_occ;
  assign space     = DEPTH - r_occ;
  assign pkt_count = r_pkt_cnt;

  m_ram_2port_sync #(
    .WIDTH (WIDTH),
    .AW    (DEPTH_LOG2)
  ) u_ram (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_clr     (clear),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (datain),
    .i_rd_en   (w_load),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (dataout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_occ     <= '0;
      r_pkt_cnt <= '0;
      r_out_vld <= 1'b0;
    end else if (clear) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_occ     <= '0;
      r_pkt_cnt <= '0;
      r_out_vld <= 1'b0;
    end else begin
      if (w_wr)   r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_load) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_ram_cnt <= r_ram_cnt + (w_wr ? ONE : '0) - (w_load ? ONE : '0);
      r_occ     <= r_occ + (w_wr ? ONE : '0) - (w_rd ? ONE : '0);
      r_out_vld <= w_load | (r_out_vld & ~w_rd);
      if (w_inc && !w_dec)      r_pkt_cnt <= r_pkt_cnt + ONE;
      else if (!w_inc && w_dec) r_pkt_cnt <= r_pkt_cnt - ONE;
    end
  end

  // A full FIFO with no complete frame can only drain by releasing early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= GATED;
    end else if (clear) begin
      r_state <= GATED;
    end else begin
      unique case (r_state)
        GATED:   if ((PKT_MODE != 0) && (r_occ == DEPTH) && (r_pkt_cnt == '0)) r_state <= RELEASE;
        RELEASE: if (w_rd && dataout[EOF_BIT]) r_state <= GATED;
        default: r_state <= GATED;
      endcase
    end
  end

endmodule

// File: tb/tb_m_fifo_sync_pkt.sv
// Bench for m_fifo_sync_pkt: packet-mode and plain instances at depth 16,
// checked against a queue model of the stored words.
module tb_m_fifo_sync_pkt;

  localparam int W    = 36;
  localparam int L    = 4;
  localparam int D    = 16;
  localparam int EOFB = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, clear, src_i, dst_i;
  logic [W-1:0] din;
  int           sel;

  logic         p_src_i, p_dst_i, f_src_i, f_dst_i;
  logic         p_dst_o, p_src_o, f_dst_o, f_src_o;
  logic [W-1:0] p_dout, f_dout;
  logic [15:0]  p_space, p_occ, p_pkt, f_space, f_occ, f_pkt;

  logic         o_dst, o_src;
  logic [W-1:0] o_dout;
  logic [15:0]  o_space, o_occ, o_pkt;

  assign p_src_i = (sel == 0) && src_i;
  assign p_dst_i = (sel == 0) && dst_i;
  assign f_src_i = (sel == 1) && src_i;
  assign f_dst_i = (sel == 1) && dst_i;

  m_fifo_sync_pkt #(.WIDTH(W), .DEPTH_LOG2(L), .PKT_MODE(1), .EOF_BIT(EOFB)) u_pkt (
    .clk(clk), .reset(reset), .clear(clear), .datain(din),
    .src_rdy_i(p_src_i), .dst_rdy_o(p_dst_o), .dataout(p_dout),
    .src_rdy_o(p_src_o), .dst_rdy_i(p_dst_i),
    .space(p_space), .occupied(p_occ), .pkt_count(p_pkt));

  m_fifo_sync_pkt #(.WIDTH(W), .DEPTH_LOG2(L), .PKT_MODE(0), .EOF_BIT(EOFB)) u_plain (
    .clk(clk), .reset(reset), .clear(clear), .datain(din),
    .src_rdy_i(f_src_i), .dst_rdy_o(f_dst_o), .dataout(f_dout),
    .src_rdy_o(f_src_o), .dst_rdy_i(f_dst_i),
    .space(f_space), .occupied(f_occ), .pkt_count(f_pkt));

  always_comb begin
    o_dst   = (sel == 1) ? f_dst_o : p_dst_o;
    o_src   = (sel == 1) ? f_src_o : p_src_o;
    o_dout  = (sel == 1) ? f_dout  : p_dout;
    o_space = (sel == 1) ? f_space : p_space;
    o_occ   = (sel == 1) ? f_occ   : p_occ;
    o_pkt   = (sel == 1) ? f_pkt   : p_pkt;
  end

  // Reference: the stored words in order, each tagged with its write edge.
  typedef struct {
    logic [W-1:0] d;
    int           we;
  } ent_t;

  ent_t q[$];
  int   edge_n;
  bit   rel;
  int   n_cmp, n_bad, n_pop;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pkts();
    int n = 0;
    foreach (q[i]) if (q[i].d[EOFB]) n++;
    return n;
  endfunction

  function automatic logic [W-1:0] rnd_word(input bit eof);
    logic [W-1:0] w;
    w[31:0]  = $urandom;
    w[35:32] = 4'($urandom_range(15, 0));
    w[EOFB]  = eof;
    return w;
  endfunction

  // One clock: compare against the model mid-cycle, then advance the model.
  task automatic cycle();
    bit ov, srdy, dr, wr, rd, fnp, eofr;
    @(negedge clk);
    ov   = (q.size() > 0) && (q[0].we < edge_n);
    srdy = ov && (sel == 1 || rel || m_pkts() > 0);
    dr   = (q.size() != D);
    chk("occupied",  W'(o_occ),   W'(q.size()));
    chk("space",     W'(o_space), W'(D - q.size()));
    chk("space_sum", W'(o_space) + W'(o_occ), W'(D));
    chk("dst_rdy_o", W'(o_dst),   W'(dr));
    chk("src_rdy_o", W'(o_src),   W'(srdy));
    chk("pkt_count", W'(o_pkt),   W'(m_pkts()));
    if (ov) chk("dataout", o_dout, q[0].d);
    wr   = src_i && dr && !clear;
    rd   = srdy && dst_i && !clear;
    fnp  = (q.size() == D) && (m_pkts() == 0);
    eofr = rd && q[0].d[EOFB];
    @(posedge clk);
    edge_n++;
    if (clear) begin
      q.delete();
      rel = 1'b0;
    end else begin
      if (rd) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (wr) q.push_back('{din, edge_n});
      if (sel == 0) begin
        if (!rel && fnp)      rel = 1'b1;
        else if (rel && eofr) rel = 1'b0;
      end
    end
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_space"},   W'(o_space), W'(D));
    chk({tag, "_occ"},     W'(o_occ),   '0);
    chk({tag, "_dst_rdy"}, W'(o_dst),   W'(1));
    chk({tag, "_src_rdy"}, W'(o_src),   '0);
    chk({tag, "_pkt"},     W'(o_pkt),   '0);
    chk({tag, "_dout"},    o_dout,      '0);
  endtask

  // Asynchronous reset applied between edges, checked before the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_reset_vals(tag);
    src_i = 1'b0;
    dst_i = 1'b0;
    clear = 1'b0;
    q.delete();
    rel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    n_cmp = 0; n_bad = 0; n_pop = 0; edge_n = 0; rel = 1'b0;
    sel = 0; reset = 1'b1; clear = 1'b0; src_i = 1'b0; dst_i = 1'b0; din = '0;
    q.delete();

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 5-word frame, EOF on the last word, consumer always ready
    dst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din   = rnd_word(i == 4);
      src_i = 1'b1;
      cycle();
    end
    src_i = 1'b0;
    repeat (10) cycle();

    // Oversize frame: fill without EOF, release, then an EOF closes it
    dst_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din   = rnd_word(1'b0);
      src_i = 1'b1;
      cycle();
    end
    src_i = 1'b0;
    repeat (3) cycle();
    dst_i = 1'b1;
    repeat (5) cycle();
    din   = rnd_word(1'b1);
    src_i = 1'b1;
    cycle();
    src_i = 1'b0;
    repeat (14) cycle();
    for (int i = 0; i < 2; i++) begin
      din   = rnd_word(1'b0);
      src_i = 1'b1;
      cycle();
    end
    src_i = 1'b0;
    repeat (5) cycle();
    chk("gated_again_src", W'(o_src), '0);
    din   = rnd_word(1'b1);
    src_i = 1'b1;
    cycle();
    src_i = 1'b0;
    repeat (6) cycle();

    // Reset in the middle of a burst
    dst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din   = rnd_word(i == 2);
      src_i = 1'b1;
      cycle();
    end
    do_reset("midburst");

    // Plain FIFO: fill, refused write, simultaneous read and write when full
    sel = 1;
    dst_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      din   = rnd_word(1'b0);
      src_i = 1'b1;
      cycle();
    end
    chk("full_dst_rdy", W'(o_dst), '0);
    chk("full_space",   W'(o_space), '0);
    din   = rnd_word(1'b0);
    dst_i = 1'b1;
    cycle();
    src_i = 1'b0;
    dst_i = 1'b0;
    cycle();
    chk("rw_full_occ", W'(o_occ), W'(15));
    dst_i = 1'b1;
    repeat (17) cycle();

    // Random traffic with wrap-around, plain then packet mode
    for (int m = 1; m >= 0; m--) begin
      do_reset("pre_rand");
      sel   = m;
      n_pop = 0;
      cyc   = 0;
      while (n_pop < 100 && cyc < 3000) begin
        src_i = 1'($urandom_range(1, 0));
        dst_i = 1'($urandom_range(1, 0));
        din   = rnd_word($urandom_range(3, 0) == 0);
        cycle();
        cyc++;
      end
      chk("rand_pops_done", W'(n_pop >= 100), W'(1));
    end

    // Clear with three complete frames held
    do_reset("pre_clear");
    sel   = 0;
    dst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din   = rnd_word(i[0]);
      src_i = 1'b1;
      cycle();
    end
    src_i = 1'b0;
    repeat (2) cycle();
    chk("three_frames", W'(o_pkt), W'(3));
    clear = 1'b1;
    src_i = 1'b1;
    dst_i = 1'b1;
    din   = rnd_word(1'b1);
    cycle();
    clear = 1'b0;
    src_i = 1'b0;
    dst_i = 1'b0;
    chk("clear_pkt", W'(o_pkt), '0);
    chk("clear_occ", W'(o_occ), '0);
    chk("clear_src", W'(o_src), '0);
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m_fifo_sync_pkt.md
# m_fifo_sync_pkt

Single-clock, parametrised successor to the two-clock cascade FIFO on the framed 36-bit datapath. Width, depth and packet mode are parameters. In packet mode the output is held back until a complete frame (SOF..EOF) is stored. Word-level space and occupancy are reported, plus a count of complete frames. It sits between framed producers and consumers inside one clock domain, where the cascade FIFO's clock crossing is not needed.

## Interface
- `WIDTH`, 36: data word width in bits.
- `DEPTH_LOG2`, 9: log2 of the storage depth. Total capacity is 2**DEPTH_LOG2 words, including the output register. Legal range is 2..15.
- `PKT_MODE`, 1: 1 gates the output per complete frame; 0 gives a plain FIFO.
- `EOF_BIT`, 33: bit index in the word that marks end of frame.
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous flush, same effect as reset.
- `datain`  in  WIDTH: write word.
- `src_rdy_i`  in  1: the upstream source has a valid word.
- `dst_rdy_o`  out  1: the FIFO can accept a word.
- `dataout`  out  WIDTH: head word.
- `src_rdy_o`  out  1: `dataout` is valid and released to the consumer.
- `dst_rdy_i`  in  1: the downstream consumer takes the word.
- `space`  out  16: free words.
- `occupied`  out  16: stored words.
- `pkt_count`  out  16: number of complete frames held (EOF words written and not yet read).

## Operation
- A write occurs when `src_rdy_i && dst_rdy_o`. `dst_rdy_o = (occupied != DEPTH)`.
- A read occurs when `src_rdy_o && dst_rdy_i`.
- Storage is a RAM with wrapping read and write pointers of DEPTH_LOG2 bits, followed by a one-word output register.
  - `occupied` counts the RAM words plus the output register.
  - The invariant `space + occupied = 2**DEPTH_LOG2` holds on every cycle.
- `pkt_count`:
  - Increments on a write whose `datain[EOF_BIT]` is 1.
  - Decrements on a read whose `dataout[EOF_BIT]` is 1.
  - If both happen in the same cycle, it is unchanged.
- Output gate FSM, active only when `PKT_MODE=1`. The states are GATED and RELEASE.
  - GATED: `src_rdy_o = out_valid && pkt_count != 0`.
    - Go to RELEASE when `occupied == DEPTH` and `pkt_count == 0`. This is the oversize frame; without it the FIFO would deadlock.
  - RELEASE: `src_rdy_o = out_valid`.
    - Go back to GATED on a read of an EOF word.
  - With `PKT_MODE=0`, `src_rdy_o = out_valid` at all times.
- On reset or `clear`, every output returns to its reset value at the next edge; data already in flight is discarded.
- Simultaneous read and write when full: the write is refused, because `dst_rdy_o` is 0 in that cycle. The read proceeds.
- Simultaneous read and write when not full: both proceed and `occupied` is unchanged.

## Timing
- Reset values:
  - `dst_rdy_o=1`, `src_rdy_o=0`, `dataout=0`.
  - `space=2**DEPTH_LOG2`, `occupied=0`, `pkt_count=0`.
  - FSM state is GATED.
- The counters update at the edge that performs the transfer.
- Latency into an empty FIFO: a word written at edge N is in the output register after edge N+1. `src_rdy_o` rises after N+1, subject to the gate.
- Read throughput: back-to-back reads give one word per cycle with no bubbles while data is available. The output register refills at the same edge as the read.
- The RAM has a 1-cycle registered read port and no read-during-write hazard: a head word written at edge N is not read from the RAM before N+1.
- `dst_rdy_o` is combinational from the registered `occupied` only, with no path from `dst_rdy_i`.

## Structure
- Shared package `fifo_pkg` holds:
  - the `gate_state_t` enum (GATED, RELEASE);
  - the `CNT_W = 16` constant;
  - `function depth(log2)`.
- Sub-module `m_ram_2port_sync`: a simple dual-port RAM, WIDTH by 2**DEPTH_LOG2, with a registered read port. The FIFO top holds the pointers, counters, output register and FSM.

## Test plan
- Reset with `DEPTH_LOG2=4`: `space=16`, `occupied=0`, `dst_rdy_o=1`, `src_rdy_o=0`. Assert `reset` mid-burst: all outputs return to these values at once.
- `PKT_MODE=1`, write a 5-word frame (EOF on word 5) with `dst_rdy_i=1`:
  - `src_rdy_o` stays 0 through word 4.
  - It rises one cycle after the EOF write.
  - Words 1..5 then stream out on consecutive cycles, and `pkt_count` goes 1→0.
- `PKT_MODE=0`, depth 16, fill with 16 words: `dst_rdy_o=0`, `space=0`. Do a simultaneous read and write: the read completes, the write is stalled, and `occupied` goes to 15.
- Oversize frame: write 16 words with no EOF (`PKT_MODE=1`, depth 16).
  - The FSM enters RELEASE and the words drain.
  - The FSM returns to GATED after the EOF word is read.
- Wrap-around: push and pop 100 random words with random `src_rdy_i`/`dst_rdy_i` at depth 16. The output order matches a scoreboard, and `space+occupied=16` holds every cycle.
- `clear` asserted with 3 frames held: the next cycle shows `pkt_count=0`, `occupied=0`, `src_rdy_o=0`.
